// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: programmable baud divisor, DATA_BITS/STOP_BITS, runtime parity.
// Optional line-break insertion is compiled in with `define UART_TX_BREAK_EN (adds tx_break input).
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bidx_q, bidx_d;
  logic                 sidx_q, sidx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 brk_q;
  logic                 brk_now;
  logic                 bit_end;
  logic                 ready_c;

`ifdef UART_TX_BREAK_EN
  assign brk_now = tx_break;

  // Registered copy lets a release restore tx=1 on the following edge,
  // while a break raised mid-frame is already visible on the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) brk_q <= 1'b0;
    else        brk_q <= tx_break;
  end
`else
  assign brk_now = 1'b0;
  assign brk_q   = 1'b0;
`endif

  assign bit_end  = (cnt_q == div_q - ONE);
  assign ready_c  = (state_q == S_IDLE) && !brk_q && !brk_now;
  assign in_ready = ready_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shift_d   = shift_q;
    bidx_d    = bidx_q;
    sidx_d    = sidx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx        = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;

    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + ONE;

    unique case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        tx    = !brk_q;
        cnt_d = '0;
        if (in_valid && ready_c) begin
          state_d   = S_START;
          shift_d   = in_data;
          div_d     = (baud_div == '0) ? ONE : baud_div;
          par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d = (parity_mode == 2'b10) ? ~(^in_data) : (^in_data);
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          bidx_d  = '0;
        end
      end
      S_DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bidx_q == 4'(DATA_BITS - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            sidx_d  = 1'b0;
          end else begin
            bidx_d = bidx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        tx = par_bit_q;
        if (bit_end) begin
          state_d = S_STOP;
          sidx_d  = 1'b0;
        end
      end
      S_STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          if (sidx_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            sidx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      shift_q   <= '0;
      bidx_q    <= '0;
      sidx_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      bidx_q    <= bidx_d;
      sidx_q    <= sidx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: one 8N1-style instance and one STOP_BITS=2 instance.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] div1, div2;
  logic [1:0]  pm1, pm2;
  logic [7:0]  data1, data2;
  logic        valid1, valid2;
  logic        ready1, ready2, tx1, tx2, busy1, busy2, done1, done2;
  logic        brk1, brk2;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_div(div1), .parity_mode(pm1),
    .in_data(data1), .in_valid(valid1),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk1),
`endif
    .in_ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(2), .DIV_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .baud_div(div2), .parity_mode(pm2),
    .in_data(data2), .in_valid(valid2),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk2),
`endif
    .in_ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );

  typedef struct {
    int unsigned div;
    logic [1:0]  pm;
    logic [7:0]  data;
    int unsigned eff;
    logic        par;
    int unsigned len;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input vec_t v, input int unsigned idx);
    logic        seq [16];
    int unsigned n, busy_cnt, dcnt, dpos, cyc;
    logic        ok;
    @(negedge clk);
    chk($sformatf("v%0d ready_pre", idx), ready1, 1);
    div1 = v.div[15:0]; pm1 = v.pm; data1 = v.data; valid1 = 1'b1;
    @(posedge clk); #1;
    // Scramble configuration right after accept; the frame must ignore it.
    valid1 = 1'b0; div1 = 16'd10; pm1 = ~v.pm; data1 = ~v.data;
    n = 0;
    seq[n] = 1'b0; n++;
    for (int unsigned i = 0; i < 8; i++) begin seq[n] = v.data[i]; n++; end
    if (v.pm == 2'b01 || v.pm == 2'b10) begin seq[n] = v.par; n++; end
    seq[n] = 1'b1; n++;
    busy_cnt = 0; dcnt = 0; dpos = 0; cyc = 0;
    for (int unsigned b = 0; b < n; b++) begin
      ok = 1'b1;
      for (int unsigned c = 0; c < v.eff; c++) begin
        @(negedge clk);
        if (tx1 !== seq[b]) ok = 1'b0;
        if (busy1 === 1'b1) busy_cnt++;
        if (done1 === 1'b1) begin dcnt++; dpos = cyc; end
        cyc++;
      end
      chk($sformatf("v%0d bit%0d", idx, b), {31'd0, ok}, 1);
    end
    chk($sformatf("v%0d busy_len", idx), busy_cnt, v.len);
    chk($sformatf("v%0d done_once", idx), dcnt, 1);
    chk($sformatf("v%0d done_pos", idx), dpos, v.len - 1);
    @(negedge clk);
    chk($sformatf("v%0d idle_tx", idx), tx1, 1);
    chk($sformatf("v%0d idle_ready", idx), ready1, 1);
    chk($sformatf("v%0d idle_busy", idx), busy1, 0);
  endtask

  initial begin
    logic ok_tx, ok_rdy, ok_done, ok_busy;
    logic exp_tx;
    logic ab [10];

    tbl[0] = '{div: 4, pm: 2'b00, data: 8'hA5, eff: 4, par: 1'b0, len: 40};
    tbl[1] = '{div: 4, pm: 2'b01, data: 8'hA5, eff: 4, par: 1'b0, len: 44};
    tbl[2] = '{div: 4, pm: 2'b10, data: 8'hA5, eff: 4, par: 1'b1, len: 44};
    tbl[3] = '{div: 0, pm: 2'b00, data: 8'h55, eff: 1, par: 1'b0, len: 10};
    tbl[4] = '{div: 1, pm: 2'b11, data: 8'h55, eff: 1, par: 1'b0, len: 10};
    tbl[5] = '{div: 2, pm: 2'b01, data: 8'h07, eff: 2, par: 1'b1, len: 22};
    tbl[6] = '{div: 3, pm: 2'b10, data: 8'h00, eff: 3, par: 1'b1, len: 33};

    div1 = '0; pm1 = '0; data1 = '0; valid1 = 1'b0; brk1 = 1'b0;
    div2 = '0; pm2 = '0; data2 = '0; valid2 = 1'b0; brk2 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst tx1", tx1, 1);
    chk("rst ready1", ready1, 1);
    chk("rst busy1", busy1, 0);
    chk("rst done1", done1, 0);
    chk("rst tx2", tx2, 1);
    chk("rst ready2", ready2, 1);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 7; i++) run_frame(tbl[i], i);

    // Two stop bits, back-to-back frames with in_valid held high.
    @(negedge clk);
    chk("b2b ready_pre", ready2, 1);
    div2 = 16'd3; pm2 = 2'b00; data2 = 8'h00; valid2 = 1'b1;
    @(posedge clk); #1;
    data2 = 8'hFF;
    ok_tx = 1'b1; ok_rdy = 1'b1; ok_done = 1'b1; ok_busy = 1'b1;
    for (int unsigned c = 0; c < 67; c++) begin
      @(negedge clk);
      exp_tx = !((c < 27) || (c >= 34 && c < 37));
      if (tx2 !== exp_tx) ok_tx = 1'b0;
      if (ready2 !== (c == 33)) ok_rdy = 1'b0;
      if (done2 !== (c == 32 || c == 66)) ok_done = 1'b0;
      if (busy2 !== (c != 33)) ok_busy = 1'b0;
      if (c == 34) valid2 = 1'b0;
    end
    chk("b2b tx", {31'd0, ok_tx}, 1);
    chk("b2b ready", {31'd0, ok_rdy}, 1);
    chk("b2b done", {31'd0, ok_done}, 1);
    chk("b2b busy", {31'd0, ok_busy}, 1);
    @(negedge clk);
    chk("b2b idle_ready", ready2, 1);

    // Asynchronous reset during data bit 3, then a clean frame.
    @(negedge clk);
    div1 = 16'd4; pm1 = 2'b00; data1 = 8'hA5; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    repeat (18) @(negedge clk);
    chk("mid bit3 tx", tx1, 0);
    chk("mid busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst tx", tx1, 1);
    chk("arst busy", busy1, 0);
    chk("arst ready", ready1, 1);
    chk("arst done", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(tbl[0], 10);

`ifdef UART_TX_BREAK_EN
    ab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    div1 = 16'd1; pm1 = 2'b00; data1 = 8'hA5; valid1 = 1'b1;
    @(posedge clk); #1;
    brk1 = 1'b1; data1 = 8'h3C;
    ok_tx = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx1 !== ab[c]) ok_tx = 1'b0;
    end
    chk("brk frame intact", {31'd0, ok_tx}, 1);
    @(negedge clk);
    chk("brk idle tx", tx1, 0);
    chk("brk idle ready", ready1, 0);
    chk("brk idle busy", busy1, 0);
    ok_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy1 !== 1'b0 || tx1 !== 1'b0) ok_busy = 1'b0;
    end
    chk("brk holds", {31'd0, ok_busy}, 1);
    brk1 = 1'b0; valid1 = 1'b0;
    #1;
    chk("brk release pre-edge tx", tx1, 0);
    @(negedge clk);
    chk("brk release tx", tx1, 1);
    chk("brk release ready", ready1, 1);
`else
    ab = '{default: 1'b0};
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
